ble_uart_tx: RTL and testbench
==============================

BLE_UART_TX -- requirements
Module: ble_uart_tx

Interface
REQ-001 The block SHALL have parameter CLKS_PER_BIT, default 868, giving clock cycles per UART bit (100 MHz / 115200); legal values are 2 and above.
REQ-002 The block SHALL have parameter FIFO_DEPTH, default 16, giving the byte capacity of the TX FIFO; it SHALL be a power of two, 2 and above.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-005 The block SHALL have port byte_ready, input, 1 bit: write strobe from the BLE setup stage, one byte per high cycle.
REQ-006 The block SHALL have port cmd_byte, input, 8 bits: data byte, sampled when byte_ready=1.
REQ-007 The block SHALL have port tx_full, output, 1 bit: FIFO holds FIFO_DEPTH bytes.
REQ-008 The block SHALL have port tx_empty, output, 1 bit: FIFO holds 0 bytes.
REQ-009 The block SHALL have port tx_busy, output, 1 bit: a frame is in progress (state not IDLE).
REQ-010 The block SHALL have port overflow, output, 1 bit: sticky flag, set when a write is dropped.
REQ-011 The block SHALL have port tx, output, 1 bit: UART serial line, registered, idle high.

Function
REQ-012 The FIFO write SHALL be accepted at a rising edge iff byte_ready=1 and tx_full=0 at that edge, storing cmd_byte at the write pointer.
REQ-013 A write with tx_full=1 SHALL be dropped, leave FIFO contents and count unchanged, and set overflow=1 from the next cycle until reset.
REQ-014 tx_full and tx_empty SHALL be decoded from a count register of width clog2(FIFO_DEPTH)+1; pointers SHALL be clog2(FIFO_DEPTH) bits and wrap modulo FIFO_DEPTH.
REQ-015 A simultaneous accepted write and pop SHALL leave the count unchanged; a write while full is rejected even if a pop occurs in the same cycle.
REQ-016 The state machine SHALL have states IDLE, START, DATA and STOP, plus a baud counter of 0..CLKS_PER_BIT-1 and a 3-bit bit index.
REQ-017 In IDLE, tx SHALL be 1; if tx_empty=0, the next edge SHALL pop the head byte into the shift register, set tx<=0, clear the baud counter and enter START.
REQ-018 START SHALL hold tx=0 for exactly CLKS_PER_BIT cycles, then drive bit 0 and enter DATA with bit index 0.
REQ-019 DATA SHALL send 8 bits LSB first, each for CLKS_PER_BIT cycles; after bit 7 it SHALL drive tx<=1 and enter STOP.
REQ-020 STOP SHALL hold tx=1 for CLKS_PER_BIT cycles; at its end, if tx_empty=0, it SHALL pop and go directly to START (tx<=0, no idle gap); otherwise it SHALL go to IDLE.
REQ-021 A frame SHALL be 8N1, exactly 10*CLKS_PER_BIT cycles long.
REQ-022 Latency: a byte written at edge N into an empty FIFO with the block in IDLE SHALL drive tx low at edge N+1.
REQ-023 Bytes SHALL be transmitted in write order with no loss or duplication while no overflow occurs.
REQ-024 Writes SHALL be accepted in every state, including mid-frame.

Reset
REQ-025 While rst=1, the block SHALL hold tx=1, tx_busy=0, tx_empty=1, tx_full=0, overflow=0, pointers, count and counters at 0, and state IDLE.
REQ-026 Assertion of rst mid-frame SHALL abort the frame immediately (tx=1 asynchronously) and discard all FIFO contents.
REQ-027 Following rst release, the block SHALL transmit nothing until a new byte is written.

Verification (CLKS_PER_BIT=4, FIFO_DEPTH=4)
REQ-028 Scenario: one write of 0x41 in IDLE -> tx falls the next edge; the line is 0,1,0,0,0,0,0,1,0,1, each bit held 4 cycles (40 cycles total); then tx_busy=0 and tx_empty=1.
REQ-029 Scenario: 3 back-to-back writes 0x0D, 0x0A, 0x55 -> 3 contiguous frames (120 cycles), stop to start with no gap, order preserved.
REQ-030 Scenario: 6 consecutive writes while the first frame is in progress -> 1 byte popped plus 4 stored, 1 dropped, overflow=1 and tx_full=1; the first 5 bytes are transmitted.
REQ-031 Scenario: a write and a pop in the same cycle with count=2 -> count stays 2 and the data order is intact.
REQ-032 Scenario: rst pulsed mid-DATA with 2 bytes queued -> tx=1 at once, tx_empty=1, and no further frames are sent.
REQ-033 Scenario: 8 writes across multiple frames -> pointers wrap and all 8 bytes are received correctly by the bench UART monitor.

Source files
------------

// File: rtl/ble_uart_tx_if.sv
// Write-side and status signals between the BLE setup stage and the UART transmitter.
// The master side writes bytes and the slave side is the transmitter that drives status and the serial line.
interface ble_uart_tx_if;
   logic       byte_ready;
   logic [7:0] cmd_byte;
   logic       tx_full;
   logic       tx_empty;
   logic       tx_busy;
   logic       overflow;
   logic       tx;

   modport master (
      output byte_ready,
      output cmd_byte,
      input  tx_full,
      input  tx_empty,
      input  tx_busy,
      input  overflow,
      input  tx
   );

   modport slave (
      input  byte_ready,
      input  cmd_byte,
      output tx_full,
      output tx_empty,
      output tx_busy,
      output overflow,
      output tx
   );
endinterface

// File: rtl/ble_uart_tx.sv
// 8N1 UART transmitter fed by a small byte FIFO.
// Frames go out back to back, with no idle gap, while the FIFO still holds data.
module ble_uart_tx #(
   parameter int CLKS_PER_BIT = 868,
   parameter int FIFO_DEPTH   = 16
) (
   input  logic         clk,
   input  logic         rst,
   ble_uart_tx_if.slave bus
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;
   localparam int BW = $clog2(CLKS_PER_BIT);
   localparam logic [BW-1:0] BAUD_LAST  = BW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] COUNT_FULL = CW'(FIFO_DEPTH);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   state_t        state_q, state_d;
   logic [BW-1:0] baud_q, baud_d;
   logic [2:0]    bit_idx_q, bit_idx_d;
   logic [7:0]    shift_q, shift_d;
   logic          tx_q, tx_d;
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          ovf_q, ovf_d;

   logic [7:0]    fifo_mem [FIFO_DEPTH];

   logic          full;
   logic          empty;
   logic          wr_en;
   logic          pop;
   logic          baud_done;
   logic [7:0]    head;

   assign full      = (count_q == COUNT_FULL);
   assign empty     = (count_q == '0);
   assign wr_en     = bus.byte_ready & ~full;
   assign baud_done = (baud_q == BAUD_LAST);
   assign head      = fifo_mem[rd_ptr_q];

   // The transmit path is a shift register: tx always carries the bit that sits at shift_q[0]
   // once a data bit starts, so each bit boundary shifts right and presents the next LSB.
   always_comb begin
      state_d   = state_q;
      baud_d    = baud_q;
      bit_idx_d = bit_idx_q;
      shift_d   = shift_q;
      tx_d      = tx_q;
      pop       = 1'b0;

      case (state_q)
         IDLE: begin
            tx_d = 1'b1;
            if (!empty) begin
               pop     = 1'b1;
               shift_d = head;
               tx_d    = 1'b0;
               baud_d  = '0;
               state_d = START;
            end
         end

         START: begin
            if (baud_done) begin
               baud_d    = '0;
               tx_d      = shift_q[0];
               bit_idx_d = '0;
               state_d   = DATA;
            end else begin
               baud_d = baud_q + BW'(1);
            end
         end

         DATA: begin
            if (baud_done) begin
               baud_d = '0;
               if (bit_idx_q == 3'd7) begin
                  tx_d    = 1'b1;
                  state_d = STOP;
               end else begin
                  shift_d   = {1'b0, shift_q[7:1]};
                  tx_d      = shift_q[1];
                  bit_idx_d = bit_idx_q + 3'd1;
               end
            end else begin
               baud_d = baud_q + BW'(1);
            end
         end

         STOP: begin
            if (baud_done) begin
               baud_d = '0;
               // Chain straight into the next start bit so queued bytes leave without a gap.
               if (!empty) begin
                  pop     = 1'b1;
                  shift_d = head;
                  tx_d    = 1'b0;
                  state_d = START;
               end else begin
                  state_d = IDLE;
               end
            end else begin
               baud_d = baud_q + BW'(1);
            end
         end

         default: begin
            tx_d    = 1'b1;
            state_d = IDLE;
         end
      endcase
   end

   // Pointers are exactly AW bits wide, so a power-of-two depth makes them wrap on their own.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      ovf_d    = ovf_q | (bus.byte_ready & full);

      if (wr_en) begin
         wr_ptr_d = wr_ptr_q + AW'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + AW'(1);
      end

      case ({wr_en, pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         baud_q    <= '0;
         bit_idx_q <= '0;
         shift_q   <= '0;
         tx_q      <= 1'b1;
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         count_q   <= '0;
         ovf_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         baud_q    <= baud_d;
         bit_idx_q <= bit_idx_d;
         shift_q   <= shift_d;
         tx_q      <= tx_d;
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         count_q   <= count_d;
         ovf_q     <= ovf_d;
      end
   end

   // Storage needs no reset: the count alone decides which entries are valid.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         fifo_mem[wr_ptr_q] <= bus.cmd_byte;
      end
   end

   assign bus.tx       = tx_q;
   assign bus.tx_busy  = (state_q != IDLE);
   assign bus.tx_empty = empty;
   assign bus.tx_full  = full;
   assign bus.overflow = ovf_q;

endmodule

// File: tb/tb_ble_uart_tx.sv
// Directed bench for ble_uart_tx with CLKS_PER_BIT=4 and FIFO_DEPTH=4.
// A small UART receiver collects the bytes that go out so they can be compared with the bytes that were written.
module tb_ble_uart_tx;

   localparam int CPB = 4;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   ble_uart_tx_if bus();

   ble_uart_tx #(
      .CLKS_PER_BIT (CPB),
      .FIFO_DEPTH   (4)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int         n_vec = 0;
   int         n_err = 0;
   logic [7:0] rx_q[$];
   logic [7:0] exp_q[$];
   int         frame_err = 0;
   int         busy_cnt = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // Start-bit detection, then a sample in the middle of every bit.
   bit         mon_active = 1'b0;
   int         mon_cnt = 0;
   logic [7:0] mon_byte = 8'h00;

   always @(negedge clk) begin
      if (rst) begin
         mon_active = 1'b0;
         mon_cnt    = 0;
      end else if (mon_active) begin
         if (mon_cnt % CPB == CPB / 2) begin
            if (mon_cnt / CPB == 0) begin
               if (bus.tx !== 1'b0) frame_err++;
            end else if (mon_cnt / CPB <= 8) begin
               mon_byte[mon_cnt / CPB - 1] = bus.tx;
            end else begin
               if (bus.tx !== 1'b1) frame_err++;
               rx_q.push_back(mon_byte);
               $display("rx byte 0x%02h", mon_byte);
               mon_active = 1'b0;
            end
         end
         mon_cnt++;
      end else if (bus.tx === 1'b0) begin
         mon_active = 1'b1;
         mon_cnt    = 1;
      end
   end

   always @(negedge clk) begin
      if (bus.tx_busy === 1'b1) busy_cnt++;
   end

   // Called at a negedge; the write lands on the next rising edge and the task returns at the following negedge.
   task automatic wr(input logic [7:0] b, input bit accept);
      bus.byte_ready = 1'b1;
      bus.cmd_byte   = b;
      if (accept) exp_q.push_back(b);
      @(negedge clk);
      bus.byte_ready = 1'b0;
      $display("write 0x%02h (accept expected %0d)", b, accept);
   endtask

   task automatic wait_idle(input string tag, input int max_cycles);
      int i;
      for (i = 0; i < max_cycles; i++) begin
         if (!bus.tx_busy && bus.tx_empty) break;
         @(negedge clk);
      end
      check(tag, 32'(i < max_cycles), 32'd1);
   endtask

   task automatic check_rx(input string tag);
      check({tag, "_count"}, 32'(rx_q.size()), 32'(exp_q.size()));
      for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
         check(tag, 32'(rx_q[i]), 32'(exp_q[i]));
      end
      check({tag, "_frame_err"}, 32'(frame_err), 32'd0);
      rx_q.delete();
      exp_q.delete();
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [9:0] line;
      logic [7:0] s6_tab [8];
      int lows;
      int guard;

      s6_tab = '{8'h00, 8'hFF, 8'h5A, 8'hA5, 8'h01, 8'h80, 8'h3C, 8'hC3};

      rst            = 1'b1;
      bus.byte_ready = 1'b0;
      bus.cmd_byte   = 8'h00;
      repeat (3) @(negedge clk);
      check("rst_tx",       32'(bus.tx),       32'd1);
      check("rst_busy",     32'(bus.tx_busy),  32'd0);
      check("rst_empty",    32'(bus.tx_empty), 32'd1);
      check("rst_full",     32'(bus.tx_full),  32'd0);
      check("rst_overflow", 32'(bus.overflow), 32'd0);
      rst = 1'b0;
      repeat (5) @(negedge clk);
      check("post_rst_tx", 32'(bus.tx), 32'd1);

      // Single byte 0x41: exact line shape, latency and end state.
      line = {1'b1, 8'h41, 1'b0};
      wr(8'h41, 1'b1);
      check("s1_tx_before_pop", 32'(bus.tx),       32'd1);
      check("s1_not_empty",     32'(bus.tx_empty), 32'd0);
      for (int i = 0; i < 10 * CPB; i++) begin
         @(negedge clk);
         check("s1_line", 32'(bus.tx), 32'(line[i / CPB]));
      end
      @(negedge clk);
      check("s1_busy_after", 32'(bus.tx_busy),  32'd0);
      check("s1_empty_after", 32'(bus.tx_empty), 32'd1);
      check_rx("s1_rx");

      // Three back-to-back bytes: busy must stay high for exactly three frames.
      busy_cnt = 0;
      wr(8'h0D, 1'b1);
      wr(8'h0A, 1'b1);
      wr(8'h55, 1'b1);
      wait_idle("s2_idle", 300);
      check("s2_busy_cycles", 32'(busy_cnt), 32'(30 * CPB));
      check_rx("s2_rx");

      // Six consecutive writes: one popped, four stored, the sixth dropped.
      for (int k = 0; k < 6; k++) begin
         wr(8'hA1 + 8'(k), k < 5);
      end
      check("s3_full",     32'(bus.tx_full),  32'd1);
      check("s3_overflow", 32'(bus.overflow), 32'd1);
      check("s3_busy",     32'(bus.tx_busy),  32'd1);
      wait_idle("s3_idle", 500);
      check("s3_overflow_sticky", 32'(bus.overflow), 32'd1);
      check("s3_full_after",      32'(bus.tx_full),  32'd0);
      check_rx("s3_rx");

      // Reset in the middle of a data bit with two bytes still queued.
      wr(8'hC1, 1'b0);
      wr(8'hC2, 1'b0);
      wr(8'hC3, 1'b0);
      repeat (10) @(negedge clk);
      check("s5_busy_pre", 32'(bus.tx_busy), 32'd1);
      #2 rst = 1'b1;
      #1;
      check("s5_rst_tx",       32'(bus.tx),       32'd1);
      check("s5_rst_busy",     32'(bus.tx_busy),  32'd0);
      check("s5_rst_empty",    32'(bus.tx_empty), 32'd1);
      check("s5_rst_full",     32'(bus.tx_full),  32'd0);
      check("s5_rst_overflow", 32'(bus.overflow), 32'd0);
      repeat (2) @(negedge clk);
      rst  = 1'b0;
      lows = 0;
      repeat (60) begin
         @(negedge clk);
         if (bus.tx !== 1'b1) lows++;
      end
      check("s5_quiet_line", 32'(lows),         32'd0);
      check("s5_empty",      32'(bus.tx_empty), 32'd1);
      check("s5_busy",       32'(bus.tx_busy),  32'd0);
      check_rx("s5_rx");

      // A write on the same edge that the end of STOP pops: the count must stay at 2.
      wr(8'h11, 1'b1);
      wr(8'h22, 1'b1);
      wr(8'h33, 1'b1);
      repeat (38) @(negedge clk);
      wr(8'h44, 1'b1);
      check("s4_restart_tx", 32'(bus.tx),       32'd0);
      check("s4_busy",       32'(bus.tx_busy),  32'd1);
      check("s4_full_at2",   32'(bus.tx_full),  32'd0);
      check("s4_empty_at2",  32'(bus.tx_empty), 32'd0);
      wr(8'h55, 1'b1);
      check("s4_full_at3", 32'(bus.tx_full), 32'd0);
      wr(8'h66, 1'b1);
      check("s4_full_at4", 32'(bus.tx_full), 32'd1);
      wait_idle("s4_idle", 400);
      check_rx("s4_rx");

      // Eight bytes across several frames, so both pointers wrap.
      for (int k = 0; k < 8; k++) begin
         guard = 0;
         while (bus.tx_full && guard < 500) begin
            @(negedge clk);
            guard++;
         end
         check("s6_room_timeout", 32'(guard < 500), 32'd1);
         wr(s6_tab[k], 1'b1);
      end
      wait_idle("s6_idle", 600);
      check("s6_overflow", 32'(bus.overflow), 32'd0);
      check_rx("s6_rx");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
